alu_sequencer: RTL and testbench

//   Command-side driver for the accumulator ALU (A register, adder/subtractor,
//   XOR, accumulator). Accepts one operation per transaction on a valid/ready

---
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving the two-stage accumulator ALU
// One op in flight: A is presented first, then B and controls, then the accumulator is sampled.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zero,
  output logic             o_rsp_err,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_addsub,
  output logic             o_alu_xor,
  input  logic [WIDTH-1:0] i_alu_out
);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_EXEC,
    S_CAPT,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_addsub;
  logic             r_alu_xor;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        w_accept    = i_req_valid;
        if (i_req_valid) w_next = (i_req_op == OP_ILL) ? S_RESP : S_LOAD_A;
      end
      S_LOAD_A: w_next = S_EXEC;
      S_EXEC:   w_next = S_CAPT;
      S_CAPT:   w_next = S_RESP;
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Illegal ops skip the ALU entirely, so alu_a is left untouched for them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op         <= '0;
      r_b          <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_addsub <= 1'b0;
      r_alu_xor    <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= i_req_op;
            r_b  <= i_req_b;
            if (i_req_op == OP_ILL) begin
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_zero   <= 1'b0;
            end else begin
              r_rsp_err <= 1'b0;
              r_alu_a   <= i_req_a;
            end
          end
        end
        S_LOAD_A: begin
          r_alu_b      <= r_b;
          r_alu_addsub <= (r_op == OP_SUB);
          r_alu_xor    <= (r_op == OP_XOR);
        end
        S_EXEC: begin
          r_alu_addsub <= 1'b0;
          r_alu_xor    <= 1'b0;
        end
        S_CAPT: begin
          r_rsp_result <= i_alu_out;
          r_rsp_zero   <= (i_alu_out == '0);
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_err    = r_rsp_err;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_addsub = r_alu_addsub;
  assign o_alu_xor    = r_alu_xor;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural accumulator ALU
`timescale 1ns/1ps
module tb_alu_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_err;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_addsub;
  logic         alu_xor;
  logic [W-1:0] alu_out;

  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_acc = '0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // ALU: A register and accumulator both capture on every rising edge
  always @(posedge clk) begin
    m_a   <= alu_a;
    m_acc <= alu_xor ? (m_a ^ alu_b) : (alu_addsub ? (m_a - alu_b) : (m_a + alu_b));
  end
  assign alu_out = m_acc;

  alu_sequencer #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_zero   (rsp_zero),
    .o_rsp_err    (rsp_err),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_addsub (alu_addsub),
    .o_alu_xor    (alu_xor),
    .i_alu_out    (alu_out)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.err = 1'b0;
    case (op)
      2'b00:   e.res = a + b;
      2'b01:   e.res = a - b;
      2'b10:   e.res = a ^ b;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.res == '0);
    return e;
  endfunction

  task automatic send_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    ok = req_ready;
    if (ok) begin
      @(posedge clk);
      sb.push_back(model(op, a, b));
      #1;
      req_a = W'($urandom); req_b = W'($urandom); req_op = 2'($urandom);
    end
    req_valid = 1'b0;
  endtask

  // lat = low-valid samples after the acceptance edge; xh/sh record controls per sample
  task automatic wait_rsp(output int lat, output logic [3:0] xh, output logic [3:0] sh, output bit ok);
    lat = -1; xh = '0; sh = '0; ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n < 4) begin xh[n] = alu_xor; sh[n] = alu_addsub; end
      if (rsp_valid) begin ok = 1'b1; lat = n; break; end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit ok, output int lat, output logic [3:0] xh, output logic [3:0] sh,
                        output exp_t got, output exp_t exp);
    bit acc_ok;
    ok = 1'b0; lat = -1; xh = '0; sh = '0; got = 'x; exp = 'x;
    send_req(op, a, b, acc_ok);
    if (!acc_ok) return;
    wait_rsp(lat, xh, sh, ok);
    got = {rsp_result, rsp_zero, rsp_err};
    if (sb.size() > 0) exp = sb.pop_front();
    if (ok) take_rsp();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_zero, rsp_err, alu_addsub, alu_xor} !== 6'b100000)
      begin failures++; $display("FAIL reset_ctrl got=%b exp=100000", {req_ready, rsp_valid, rsp_zero, rsp_err, alu_addsub, alu_xor}); end
    checks++;
    if ({rsp_result, alu_a, alu_b} !== '0)
      begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", rsp_result, alu_a, alu_b); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp;
    run_op(2'b00, 16'h1234, 16'h0FFF, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL add_result got=%h/%b/%b exp=%h/%b/%b", got.res, got.zero, got.err, exp.res, exp.zero, exp.err); end
  endtask

  task automatic test_sub();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp;
    run_op(2'b01, 16'h0005, 16'h0007, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || got !== exp) begin failures++; $display("FAIL sub_wrap got=%h/%b/%b exp=%h/%b/%b", got.res, got.zero, got.err, exp.res, exp.zero, exp.err); end
    checks++;
    if (sh !== 4'b0010) begin failures++; $display("FAIL sub_addsub_timing got=%b exp=0010", sh); end
    run_op(2'b01, 16'hBEEF, 16'hBEEF, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || got !== exp) begin failures++; $display("FAIL sub_equal got=%h/%b/%b exp=%h/%b/%b", got.res, got.zero, got.err, exp.res, exp.zero, exp.err); end
  endtask

  task automatic test_xor();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp;
    run_op(2'b10, 16'hAAAA, 16'hFFFF, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || got !== exp) begin failures++; $display("FAIL xor_result got=%h/%b/%b exp=%h/%b/%b", got.res, got.zero, got.err, exp.res, exp.zero, exp.err); end
    checks++;
    if (xh !== 4'b0010 || sh !== 4'b0000) begin failures++; $display("FAIL xor_ctrl_timing got=%b/%b exp=0010/0000", xh, sh); end
  endtask

  task automatic test_illegal();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp;
    run_op(2'b11, 16'h1111, 16'h2222, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || lat !== 0) begin failures++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL illegal_result got=%h/%b/%b exp=%h/%b/%b", got.res, got.zero, got.err, exp.res, exp.zero, exp.err); end
    checks++;
    if (xh !== 4'b0000 || sh !== 4'b0000 || alu_a !== 16'hAAAA)
      begin failures++; $display("FAIL illegal_alu_idle got=%b/%b/%h exp=0000/0000/aaaa", xh, sh, alu_a); end
  endtask

  task automatic test_stall();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp;
    send_req(2'b01, 16'h1000, 16'h0001, ok);
    wait_rsp(lat, xh, sh, ok);
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    req_valid = 1'b1; req_op = 2'b00; req_a = 16'h0007; req_b = 16'h0008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_result, rsp_zero, rsp_err} !== {2'b10, exp})
        begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%h/%b/%b exp=1/0/%h/%b/%b", i, rsp_valid, req_ready, rsp_result, rsp_zero, rsp_err, exp.res, exp.zero, exp.err); end
    end
    take_rsp();
    run_op(2'b00, 16'h0007, 16'h0008, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || lat !== 3 || got !== exp) begin failures++; $display("FAIL stall_second got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=3", got.res, got.zero, got.err, lat, exp.res, exp.zero, exp.err); end
  endtask

  task automatic test_reset_exec();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp; bit seen;
    send_req(2'b00, 16'h00FF, 16'h0100, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_zero, rsp_err, alu_addsub, alu_xor} !== 6'b100000 || {rsp_result, alu_a, alu_b} !== '0)
      begin failures++; $display("FAIL rst_exec got=%b %h/%h/%h exp=100000 0/0/0", {req_ready, rsp_valid, rsp_zero, rsp_err, alu_addsub, alu_xor}, rsp_result, alu_a, alu_b); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= rsp_valid; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_rsp got=%b exp=0", seen); end
    run_op(2'b00, 16'h0001, 16'h0001, ok, lat, xh, sh, got, exp);
    checks++;
    if (!ok || got !== {16'h0002, 2'b00}) begin failures++; $display("FAIL rst_then_add got=%h/%b/%b exp=0002/0/0", got.res, got.zero, got.err); end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; logic [3:0] xh, sh; exp_t got, exp;
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), ok, lat, xh, sh, got, exp);
      checks++;
      if (!ok || lat !== (exp.err ? 0 : 3)) begin failures++; $display("FAIL b2b_latency idx=%0d got=%0d err=%b", i, lat, exp.err); end
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_result idx=%0d got=%h/%b/%b exp=%h/%b/%b", i, got.res, got.zero, got.err, exp.res, exp.zero, exp.err); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_xor();
    test_illegal();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
